// File: rtl/vga_sync_gen_pkg.sv
// vga_pkg: shared phase encoding, default 640x480@60 timing and total-length helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vga_pkg;

    // Phase order along a line or a frame: visible area, front porch, sync pulse, back porch.
    typedef enum logic [1:0] {ACT, FP, SYNC, BP} vga_fase_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Pixels per line including blanking.
    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Lines per frame including blanking.
    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle from the sync generator to the painter/DAC.
// Latency: n/a (wires only).
// Backpressure: none; consumers sample x/y/blank_n on pix_en.
// Signals: pix_en tick, x/y coordinates, hsync/vsync, blank_n, line_start/frame_start pulses.
interface vga_sync_gen_if;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       line_start;
    logic       frame_start;

    modport master (output pix_en, x, y, hsync, vsync, blank_n, line_start, frame_start);
    modport slave  (input  pix_en, x, y, hsync, vsync, blank_n, line_start, frame_start);
endinterface

// File: rtl/vga_sync_gen_fase_cnt.sv
// vga_fase_cnt: wrapping 10-bit position counter with ACT->FP->SYNC->BP phase FSM.
// Latency: count and phase registers move on the clk edge where inc_i is high.
// Backpressure: none; advances on every inc_i.
// Ports: clk, rst_n (async low), inc_i step; cnt_o position, fase_nxt_o next phase, wrap_o last-position step.
module vga_fase_cnt #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_i,
    output logic [9:0]          cnt_o,
    output vga_pkg::vga_fase_t  fase_nxt_o,
    output logic                wrap_o
);
    localparam int         TOTAL    = ACTIVE + FP + SYNC + BP;
    localparam logic [9:0] LAST     = 10'(TOTAL - 1);
    localparam logic [9:0] ACT_END  = 10'(ACTIVE - 1);
    localparam logic [9:0] FP_END   = 10'(ACTIVE + FP - 1);
    localparam logic [9:0] SYNC_END = 10'(ACTIVE + FP + SYNC - 1);

    logic [9:0]         cnt_q, cnt_d;
    vga_pkg::vga_fase_t fase_q, fase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Parked on the last position so the first step lands on 0 in ACT.
            cnt_q  <= LAST;
            fase_q <= vga_pkg::BP;
        end else begin
            cnt_q  <= cnt_d;
            fase_q <= fase_d;
        end
    end

    // Phase changes are keyed off the current count so the new phase lines up with the new count.
    always_comb begin
        wrap_o = inc_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        fase_d = fase_q;
        if (inc_i) begin
            cnt_d = wrap_o ? 10'd0 : cnt_q + 10'd1;
            unique case (fase_q)
                vga_pkg::ACT:  if (cnt_q == ACT_END)  fase_d = vga_pkg::FP;
                vga_pkg::FP:   if (cnt_q == FP_END)   fase_d = vga_pkg::SYNC;
                vga_pkg::SYNC: if (cnt_q == SYNC_END) fase_d = vga_pkg::BP;
                vga_pkg::BP:   if (cnt_q == LAST)     fase_d = vga_pkg::ACT;
                default:                              fase_d = vga_pkg::BP;
            endcase
        end
    end

    assign cnt_o      = cnt_q;
    assign fase_nxt_o = fase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator (x/y, hsync, vsync, blank_n, line/frame markers).
// Latency: all outputs registered; x/y, syncs, blank_n and pulses change together on the clk pix_en is high.
// Backpressure: none; free-running source, downstream samples on pix_en.
// Ports: clk, reset (async active-low), vga (master modport of vga_sync_gen_if).
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = VGA_H_ACTIVE,
    parameter int          H_FP     = VGA_H_FP,
    parameter int          H_SYNC   = VGA_H_SYNC,
    parameter int          H_BP     = VGA_H_BP,
    parameter int          V_ACTIVE = VGA_V_ACTIVE,
    parameter int          V_FP     = VGA_V_FP,
    parameter int          V_SYNC   = VGA_V_SYNC,
    parameter int          V_BP     = VGA_V_BP,
    parameter int          CLK_DIV  = 2,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_param
        $error("vga_sync_gen: totals must fit 10 bits and CLK_DIV must be 1..4");
    end

    logic [1:0] div_cnt_q, div_cnt_d;
    logic       tick;
    logic       pix_en_q, line_start_q, frame_start_q;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
    logic [9:0] h_cnt, v_cnt;
    logic       h_wrap, v_wrap;
    vga_fase_t  h_fase_d, v_fase_d;

    // tick is the last divider count; with CLK_DIV=1 the divider sits at 0 and ticks every clk.
    always_comb begin
        tick      = (div_cnt_q == 2'(CLK_DIV - 1));
        div_cnt_d = tick ? 2'd0 : div_cnt_q + 2'd1;
    end

    vga_fase_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .inc_i      (tick),
        .cnt_o      (h_cnt),
        .fase_nxt_o (h_fase_d),
        .wrap_o     (h_wrap)
    );

    vga_fase_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .inc_i      (h_wrap),
        .cnt_o      (v_cnt),
        .fase_nxt_o (v_fase_d),
        .wrap_o     (v_wrap)
    );

    // Decoding from the next phase keeps syncs/blank_n registered yet aligned with the counters.
    always_comb begin
        hsync_d   = (h_fase_d == SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_d   = (v_fase_d == SYNC) ? SYNC_POL : ~SYNC_POL;
        blank_n_d = (h_fase_d == ACT) && (v_fase_d == ACT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q     <= 2'd0;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            blank_n_q     <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= tick;
            // h_wrap already implies tick, so the pulses can only coincide with pix_en.
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.x           = h_cnt;
    assign vga.y           = v_cnt;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_n     = blank_n_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three generator configurations checked every clk against a position-arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    int   k_a = 0;
    int   k_b = 0;
    int   k_c = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    bit   run_chk = 1'b0;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    // A: default 640x480 timing, /2 divider, active-low syncs.
    vga_sync_gen #(.CLK_DIV(2), .SYNC_POL(1'b0)) u_a (
        .clk(clk), .reset(rst_a), .vga(if_a.master));

    // B: miniature timing, divider bypassed, active-high syncs.
    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) u_b (.clk(clk), .reset(rst_b), .vga(if_b.master));

    // C: miniature timing, /3 divider, active-low syncs.
    vga_sync_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(3), .SYNC_POL(1'b0)
    ) u_c (.clk(clk), .reset(rst_c), .vga(if_c.master));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: k clks since reset release give floor(k/D) pixel ticks; tick n lands on raster
    // position n-1 (mod frame size), and every output is a function of that position.
    task automatic check_dut(input string tag, input logic rst, input int k, input int d,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input logic pol, input logic pe, input logic [9:0] x,
                             input logic [9:0] y, input logic hs_o, input logic vs_o,
                             input logic bn, input logic ls, input logic fs);
        int   ht, vt, kk, n, p, ex, ey;
        logic epe, ehs, evs, ebn, els, efs;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        kk  = rst ? k : 0;
        n   = kk / d;
        p   = (n == 0) ? ht * vt - 1 : (n - 1) % (ht * vt);
        ex  = p % ht;
        ey  = p / ht;
        epe = (kk > 0) && (kk % d == 0);
        ehs = (ex >= ha + hf && ex < ha + hf + hs) ? pol : ~pol;
        evs = (ey >= va + vf && ey < va + vf + vs) ? pol : ~pol;
        ebn = (ex < ha) && (ey < va);
        els = epe && (ex == 0);
        efs = epe && (p == 0);
        chk({tag, ".pix_en"},      32'(pe),   32'(epe));
        chk({tag, ".x"},           32'(x),    32'(ex));
        chk({tag, ".y"},           32'(y),    32'(ey));
        chk({tag, ".hsync"},       32'(hs_o), 32'(ehs));
        chk({tag, ".vsync"},       32'(vs_o), 32'(evs));
        chk({tag, ".blank_n"},     32'(bn),   32'(ebn));
        chk({tag, ".line_start"},  32'(ls),   32'(els));
        chk({tag, ".frame_start"}, 32'(fs),   32'(efs));
    endtask

    always @(posedge clk) begin
        k_a <= rst_a ? k_a + 1 : 0;
        k_b <= rst_b ? k_b + 1 : 0;
        k_c <= rst_c ? k_c + 1 : 0;
    end

    always @(negedge clk) begin
        if (run_chk) begin
            check_dut("A", rst_a, k_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                      if_a.pix_en, if_a.x, if_a.y, if_a.hsync, if_a.vsync,
                      if_a.blank_n, if_a.line_start, if_a.frame_start);
            check_dut("B", rst_b, k_b, 1, 16, 4, 6, 4, 8, 2, 2, 3, 1'b1,
                      if_b.pix_en, if_b.x, if_b.y, if_b.hsync, if_b.vsync,
                      if_b.blank_n, if_b.line_start, if_b.frame_start);
            check_dut("C", rst_c, k_c, 3, 10, 2, 3, 5, 6, 1, 2, 3, 1'b0,
                      if_c.pix_en, if_c.x, if_c.y, if_c.hsync, if_c.vsync,
                      if_c.blank_n, if_c.line_start, if_c.frame_start);
        end
    end

    initial begin
        int      w;
        bit      hit;
        int unsigned r;
        @(posedge clk);
        #2 run_chk = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;

        // Drive A into the middle of its hsync pulse, then hit reset between clk edges.
        w   = 0;
        hit = 1'b0;
        while (!hit && w < 3000) begin
            @(posedge clk);
            #2;
            w++;
            hit = (if_a.x == 10'd700) && if_a.pix_en;
        end
        if (!hit) begin
            chk("wait_x700", 32'd0, 32'd1);
        end else begin
            chk("x700.hsync", 32'(if_a.hsync), 32'd0);
            rst_a = 1'b0;
            #1;
            chk("rst_async.hsync",   32'(if_a.hsync),   32'd1);
            chk("rst_async.x",       32'(if_a.x),       32'd799);
            chk("rst_async.y",       32'(if_a.y),       32'd524);
            chk("rst_async.blank_n", 32'(if_a.blank_n), 32'd0);
            chk("rst_async.pix_en",  32'(if_a.pix_en),  32'd0);
        end
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2 rst_a = 1'b1;

        // Several full lines of A; many frames of B and C.
        repeat (5000) @(posedge clk);

        // Random run lengths with random resets landing anywhere in the frame.
        for (int s = 0; s < 12; s++) begin
            repeat ($urandom_range(300, 2500)) @(posedge clk);
            #2;
            r = $urandom_range(1, 7);
            if (r[0]) rst_a = 1'b0;
            if (r[1]) rst_b = 1'b0;
            if (r[2]) rst_c = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2;
            rst_a = 1'b1;
            rst_b = 1'b1;
            rst_c = 1'b1;
        end

        repeat (200) @(posedge clk);
        #2 run_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage for the pixel painter. Generates 640x480@60 VGA timing from the system clock.
- Emits the pixel coordinates x/y that the painter uses for quadrant selection, plus hsync, vsync, blank_n and frame/line markers for the DAC and the section logic.
- All outputs are registered and advance once per pixel-enable tick.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (1..4)
SYNC_POL, 0, active level of hsync/vsync

Ports:
clk  in  1  system clock (50 MHz nominal)
reset  in  1  asynchronous, active-low reset
pix_en  out  1  one-clk pulse per pixel; downstream samples x/y/blank_n when high
x  out  10  horizontal count, 0..H_TOTAL-1
y  out  10  vertical count, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level SYNC_POL when active
vsync  out  1  vertical sync, level SYNC_POL when active
blank_n  out  1  1 in the visible area
line_start  out  1  one-clk pulse when x wraps to 0
frame_start  out  1  one-clk pulse when (x,y) wraps to (0,0)

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (reset=0, asynchronous) forces:
  - div_cnt=0, pix_en=0, line_start=0, frame_start=0, blank_n=0
  - x=H_TOTAL-1, y=V_TOTAL-1
  - hsync=vsync=~SYNC_POL
  - H phase=H_BP, V phase=V_BP
- Reset deassertion is taken synchronously on the next clk edge; no glitch on the outputs.
- Divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps.
  - pix_en is registered and high for exactly one clk when div_cnt wraps.
  - First pix_en occurs at the CLK_DIV-th rising edge after reset release.
  - CLK_DIV=1: pix_en is high every cycle after the first edge.
- On each pix_en edge, counters and all timing outputs update in the same edge, so x/y and hsync/vsync/blank_n are never skewed:
  - x = x+1, or 0 when x==H_TOTAL-1.
  - y advances only when x wraps: y+1, or 0 when y==V_TOTAL-1.
  - The first tick after reset therefore lands on (0,0) and fires line_start and frame_start together.
- Phase FSMs, one horizontal and one vertical, each with states ACT -> FP -> SYNC -> BP -> ACT:
  - H transitions at x = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and the wrap.
  - V transitions at the matching y values, evaluated only on x wrap.
- Output decode:
  - hsync = SYNC_POL iff H state==SYNC (x 656..751).
  - vsync = SYNC_POL iff V state==SYNC (y 490..491).
  - blank_n = (H state==ACT) && (V state==ACT).
- Pulses:
  - line_start and frame_start are high for one clk only: the clk after the wrapping pix_en edge, coincident with the new x/y.
  - Both are 0 on every cycle where pix_en is 0.
- Between pix_en ticks, every output except pix_en and the pulses holds its value.
- Width rule: 10-bit counters; comparisons are unsigned; parameters must satisfy H_TOTAL<=1024 and V_TOTAL<=1024 (static assertion).
- Reset mid-frame: immediate return to the reset values. The next frame begins cleanly with frame_start; no partial sync pulse is extended.

Decomposition:
- Package vga_pkg:
  - typedef enum logic [1:0] {ACT, FP, SYNC, BP} vga_fase_t
  - default 640x480 timing localparams
  - H_TOTAL/V_TOTAL helper functions
- Sub-module vga_fase_cnt: a generic counter plus phase FSM with parameters ACTIVE, FP, SYNC, BP and inputs inc/wrap_out.
  - Instantiated twice: horizontal (inc=pix_en) and vertical (inc=horizontal wrap).

Test Plan:
- Reset release, CLK_DIV=2 -> first pix_en at 2nd clk edge; x=0, y=0, line_start=frame_start=1 for one clk, blank_n=1.
- Run one line -> blank_n falls at x=640; hsync=0 for x 656..751 (96 ticks); x wraps 799->0 with y 0->1 and line_start=1.
- Run one full frame -> vsync=0 exactly for y 490..491; frame_start period = 800*525*2 = 840000 clks; blank_n high count = 307200 ticks.
- Assert reset at x=700, y=300 (inside hsync) -> hsync returns to 1 asynchronously, x=799, y=524; after release the next tick gives (0,0) with frame_start.
- CLK_DIV=1, SYNC_POL=1 -> pix_en constantly 1 after reset; hsync high only for x 656..751; frame period 420000 clks.
- Compare x/y against the painter's quadrant boundaries -> at x=320/y=240 the transitions coincide with blank_n=1 and no skew relative to hsync.
